// File: rtl/oclib_axim_to_axil_burst.sv
//==============================================================================
// Module   : oclib_axim_to_axil_burst
// Purpose  : AXI4 burst to AXI-Lite bridge, one AXI-Lite transaction per beat.
//            Optional macro: OCLIB_AXIM_TO_AXIL_4K_CHECK_EN (4 KB crossing check)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package oclib_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic        valid;
    } axi4_a_s;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        valid;
    } axi4_w_s;

    typedef struct packed {
        axi4_a_s aw;
        axi4_w_s w;
        axi4_a_s ar;
        logic    bready;
        logic    rready;
    } axi4m_32_s;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       valid;
    } axi4_b_s;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        valid;
    } axi4_r_s;

    typedef struct packed {
        logic    awready;
        logic    wready;
        logic    arready;
        axi4_b_s b;
        axi4_r_s r;
    } axi4m_32_fb_s;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic        valid;
    } axil_a_s;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        valid;
    } axil_w_s;

    typedef struct packed {
        axil_a_s aw;
        axil_w_s w;
        axil_a_s ar;
        logic    bready;
        logic    rready;
    } axil_32_s;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        arready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } axil_32_fb_s;
endpackage

module oclib_axim_to_axil_burst #(
    parameter type InType    = oclib_pkg::axi4m_32_s,
    parameter type InFbType  = oclib_pkg::axi4m_32_fb_s,
    parameter type OutType   = oclib_pkg::axil_32_s,
    parameter type OutFbType = oclib_pkg::axil_32_fb_s,
    parameter int  AddrWidth = 32,
    parameter int  DataWidth = 32
) (
    input  logic     clock,
    input  logic     reset,
    input  InType    in,
    output InFbType  inFb,
    output OutType   out,
    input  OutFbType outFb
);

    localparam logic [1:0] c_okay     = 2'b00;
    localparam logic [1:0] c_exokay   = 2'b01;
    localparam logic [1:0] c_slverr   = 2'b10;
    localparam logic [1:0] c_fixed    = 2'b00;
    localparam logic [1:0] c_incr     = 2'b01;
    localparam logic [2:0] c_max_size = 3'($clog2(DataWidth / 8));
    localparam int         c_idw      = $bits(in.aw.id);

    if (($bits(in.w.data) != DataWidth) || ($bits(outFb.rdata) != DataWidth)) begin : g_width_check
        $error("oclib_axim_to_axil_burst: DataWidth does not match the channel data width");
    end

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_DATA  = 3'd1,
        W_ISSUE = 3'd2,
        W_RESP  = 3'd3,
        W_DRAIN = 3'd4,
        W_B     = 3'd5
    } wstate_t;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_ISSUE = 3'd1,
        R_WAIT  = 3'd2,
        R_BEAT  = 3'd3,
        R_ERR   = 3'd4
    } rstate_t;

    function automatic logic f_illegal(input logic [2:0] size, input logic [1:0] burst);
        return ((burst != c_fixed) && (burst != c_incr)) || (size > c_max_size);
    endfunction

    // INCR realigns to the beat size after the first (possibly unaligned) beat
    function automatic logic [AddrWidth-1:0] f_next_addr(input logic [AddrWidth-1:0] addr,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(1) << size;
        if (burst == c_incr) begin
            return (addr & ~(step - AddrWidth'(1))) + step;
        end
        return addr;
    endfunction

    // EXOKAY folds to OKAY; the remaining codes are already ordered by severity
    function automatic logic [1:0] f_merge(input logic [1:0] acc, input logic [1:0] resp);
        logic [1:0] mapped;
        mapped = (resp == c_exokay) ? c_okay : resp;
        return (mapped > acc) ? mapped : acc;
    endfunction

`ifdef OCLIB_AXIM_TO_AXIL_4K_CHECK_EN
    function automatic logic f_cross_4k(input logic [11:0] addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        logic [19:0] end_byte;
        end_byte = {8'd0, addr} + (({12'd0, len} + 20'd1) << size);
        return (burst == c_incr) && (end_byte > 20'd4096);
    endfunction
`endif

    logic w_aw_illegal;
    logic w_ar_illegal;

    always_comb begin
`ifdef OCLIB_AXIM_TO_AXIL_4K_CHECK_EN
        w_aw_illegal = f_illegal(in.aw.size, in.aw.burst) ||
                       f_cross_4k(in.aw.addr[11:0], in.aw.len, in.aw.size, in.aw.burst);
        w_ar_illegal = f_illegal(in.ar.size, in.ar.burst) ||
                       f_cross_4k(in.ar.addr[11:0], in.ar.len, in.ar.size, in.ar.burst);
`else
        w_aw_illegal = f_illegal(in.aw.size, in.aw.burst);
        w_ar_illegal = f_illegal(in.ar.size, in.ar.burst);
`endif
    end

    logic w_unused;
    assign w_unused = ^{in.aw.lock, in.aw.cache, in.w.last, in.ar.lock, in.ar.cache};

    // Write engine
    wstate_t                r_wstate;
    logic                   r_awready, r_wready, r_bvalid;
    logic                   r_lawvalid, r_lwvalid, r_lbready;
    logic [c_idw-1:0]       r_wid;
    logic [AddrWidth-1:0]   r_waddr;
    logic [7:0]             r_wlen, r_wbeat;
    logic [2:0]             r_wsize, r_wprot;
    logic [1:0]             r_wburst, r_bresp;
    logic [DataWidth-1:0]   r_wdata;
    logic [DataWidth/8-1:0] r_wstrb;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_lawvalid <= 1'b0;
            r_lwvalid  <= 1'b0;
            r_lbready  <= 1'b0;
            r_wid      <= '0;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wbeat    <= '0;
            r_wsize    <= '0;
            r_wprot    <= '0;
            r_wburst   <= '0;
            r_bresp    <= c_okay;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (in.aw.valid && r_awready) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wid     <= in.aw.id;
                        r_waddr   <= in.aw.addr[AddrWidth-1:0];
                        r_wlen    <= in.aw.len;
                        r_wsize   <= in.aw.size;
                        r_wburst  <= in.aw.burst;
                        r_wprot   <= in.aw.prot;
                        r_wbeat   <= '0;
                        if (w_aw_illegal) begin
                            r_bresp  <= c_slverr;
                            r_wstate <= W_DRAIN;
                        end else begin
                            r_bresp  <= c_okay;
                            r_wstate <= W_DATA;
                        end
                    end
                end
                W_DATA: begin
                    if (in.w.valid && r_wready) begin
                        r_wready   <= 1'b0;
                        r_wdata    <= in.w.data;
                        r_wstrb    <= in.w.strb;
                        r_lawvalid <= 1'b1;
                        r_lwvalid  <= 1'b1;
                        r_wstate   <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    if (outFb.awready) r_lawvalid <= 1'b0;
                    if (outFb.wready)  r_lwvalid  <= 1'b0;
                    if ((!r_lawvalid || outFb.awready) && (!r_lwvalid || outFb.wready)) begin
                        r_lbready <= 1'b1;
                        r_wstate  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (outFb.bvalid && r_lbready) begin
                        r_lbready <= 1'b0;
                        r_bresp   <= f_merge(r_bresp, outFb.bresp);
                        if (r_wbeat == r_wlen) begin
                            r_bvalid <= 1'b1;
                            r_wstate <= W_B;
                        end else begin
                            r_wbeat  <= r_wbeat + 8'd1;
                            r_waddr  <= f_next_addr(r_waddr, r_wsize, r_wburst);
                            r_wready <= 1'b1;
                            r_wstate <= W_DATA;
                        end
                    end
                end
                W_DRAIN: begin
                    if (in.w.valid && r_wready) begin
                        if (r_wbeat == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_B;
                        end else begin
                            r_wbeat <= r_wbeat + 8'd1;
                        end
                    end
                end
                W_B: begin
                    if (in.bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read engine
    rstate_t              r_rstate;
    logic                 r_arready, r_rvalid, r_rlast;
    logic                 r_larvalid, r_lrready;
    logic [c_idw-1:0]     r_rid;
    logic [AddrWidth-1:0] r_raddr;
    logic [7:0]           r_rlen, r_rbeat;
    logic [2:0]           r_rsize, r_rprot;
    logic [1:0]           r_rburst, r_rresp;
    logic [DataWidth-1:0] r_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_larvalid <= 1'b0;
            r_lrready  <= 1'b0;
            r_rid      <= '0;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rbeat    <= '0;
            r_rsize    <= '0;
            r_rprot    <= '0;
            r_rburst   <= '0;
            r_rresp    <= c_okay;
            r_rdata    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (in.ar.valid && r_arready) begin
                        r_arready <= 1'b0;
                        r_rid     <= in.ar.id;
                        r_raddr   <= in.ar.addr[AddrWidth-1:0];
                        r_rlen    <= in.ar.len;
                        r_rsize   <= in.ar.size;
                        r_rburst  <= in.ar.burst;
                        r_rprot   <= in.ar.prot;
                        r_rbeat   <= '0;
                        if (w_ar_illegal) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= '0;
                            r_rresp  <= c_slverr;
                            r_rlast  <= (in.ar.len == 8'd0);
                            r_rstate <= R_ERR;
                        end else begin
                            r_larvalid <= 1'b1;
                            r_rstate   <= R_ISSUE;
                        end
                    end
                end
                R_ISSUE: begin
                    if (outFb.arready) begin
                        r_larvalid <= 1'b0;
                        r_lrready  <= 1'b1;
                        r_rstate   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (outFb.rvalid) begin
                        r_lrready <= 1'b0;
                        r_rdata   <= outFb.rdata;
                        r_rresp   <= outFb.rresp;
                        r_rlast   <= (r_rbeat == r_rlen);
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_BEAT;
                    end
                end
                R_BEAT: begin
                    if (in.rready) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rstate <= R_IDLE;
                        end else begin
                            r_raddr    <= f_next_addr(r_raddr, r_rsize, r_rburst);
                            r_rbeat    <= r_rbeat + 8'd1;
                            r_larvalid <= 1'b1;
                            r_rstate   <= R_ISSUE;
                        end
                    end
                end
                R_ERR: begin
                    if (in.rready) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        inFb           = '0;
        inFb.awready   = r_awready;
        inFb.wready    = r_wready;
        inFb.arready   = r_arready;
        inFb.b.valid   = r_bvalid;
        inFb.b.id      = r_wid;
        inFb.b.resp    = r_bresp;
        inFb.r.valid   = r_rvalid;
        inFb.r.id      = r_rid;
        inFb.r.data    = r_rdata;
        inFb.r.resp    = r_rresp;
        inFb.r.last    = r_rlast;

        out            = '0;
        out.aw.valid   = r_lawvalid;
        out.aw.addr    = 32'(r_waddr);
        out.aw.prot    = r_wprot;
        out.w.valid    = r_lwvalid;
        out.w.data     = r_wdata;
        out.w.strb     = r_wstrb;
        out.bready     = r_lbready;
        out.ar.valid   = r_larvalid;
        out.ar.addr    = 32'(r_raddr);
        out.ar.prot    = r_rprot;
        out.rready     = r_lrready;
    end

endmodule

`default_nettype wire
